// File: rtl/message_streamer_pkg.sv
// Shared constants, message ROM contents and FSM state type for the message streamer.
package message_streamer_pkg;

  localparam int unsigned DEF_MSG_COUNT = 4;
  localparam int unsigned DEF_MSG_DEPTH = 64;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_DIV_W     = 16;
  localparam int unsigned LEN_W         = $clog2(DEF_MSG_DEPTH) + 1;

  typedef logic [DEF_MSG_DEPTH*DEF_DATA_W-1:0] msg_t;

  // String literals are right-justified: the last character sits in the low byte.
  localparam msg_t MSG_ROM [DEF_MSG_COUNT] = '{
    msg_t'("Tajumulco Tacana Acatenango Fuego Sa"),
    msg_t'("Hi"),
    msg_t'("OK!"),
    msg_t'("Hola!")
  };

  // Every entry must stay <= DEF_MSG_DEPTH so index and length widths never overflow.
  localparam logic [LEN_W-1:0] MSG_LEN [DEF_MSG_COUNT] = '{
    LEN_W'(36), LEN_W'(2), LEN_W'(3), LEN_W'(5)
  };

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  function automatic logic [DEF_DATA_W-1:0] msg_char(msg_t m, int unsigned len, int unsigned idx);
    logic [DEF_DATA_W-1:0] c;
    c = '0;
    if (idx < len) c = m[(len - 1 - idx) * DEF_DATA_W +: DEF_DATA_W];
    return c;
  endfunction

endpackage

// File: rtl/message_streamer_if.sv
// Character stream handshake between the streamer and its display/UART sink.
interface message_streamer_if
  import message_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) ();
  logic [DATA_W-1:0] char_out;
  logic              char_valid;
  logic              char_ready;

  modport master (output char_out, output char_valid, input char_ready);
  modport slave  (input char_out, input char_valid, output char_ready);
endinterface

// File: rtl/message_streamer_rom.sv
// Combinational message lookup: (sel, idx) -> character and (sel) -> length.
module message_rom
  import message_streamer_pkg::*;
#(
  parameter int unsigned MSG_COUNT = DEF_MSG_COUNT,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned DATA_W    = DEF_DATA_W
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] chr,
  output logic [LEN_W-1:0]  len
);

  int unsigned s;

  // Out-of-range selects behave as empty messages.
  always_comb begin
    s   = 32'(sel);
    chr = '0;
    len = '0;
    if (s < MSG_COUNT && s < DEF_MSG_COUNT) begin
      len = MSG_LEN[s];
      chr = DATA_W'(msg_char(MSG_ROM[s], 32'(MSG_LEN[s]), 32'(idx)));
    end
  end

endmodule

// File: rtl/message_streamer.sv
// Streams one of several ROM messages over valid/ready with programmable gap and loop mode.
module message_streamer
  import message_streamer_pkg::*;
#(
  parameter int unsigned MSG_COUNT = DEF_MSG_COUNT,
  parameter int unsigned MSG_DEPTH = DEF_MSG_DEPTH,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DIV_W     = DEF_DIV_W,
  localparam int unsigned SEL_W    = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1,
  localparam int unsigned IDX_W    = $clog2(MSG_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                start,
  input  logic                abort,
  input  logic [SEL_W-1:0]    msg_sel,
  input  logic                loop_mode,
  input  logic [DIV_W-1:0]    rate_div,
  message_streamer_if.master  stream,
  output logic                busy,
  output logic                done
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
  logic [SEL_W-1:0]  sel_q, sel_d, rom_sel;
  logic              loop_q, loop_d, valid_q, valid_d, done_q, done_d;
  logic [DATA_W-1:0] char_q, char_d, rom_chr;
  logic [LEN_W-1:0]  rom_len;
  logic              load_char, accept, last;

  // While idle the ROM looks at the live select so start can check length and fetch char 0.
  assign rom_sel = (state_q == StIdle) ? msg_sel : sel_q;

  message_rom #(
    .MSG_COUNT (MSG_COUNT),
    .SEL_W     (SEL_W),
    .IDX_W     (IDX_W),
    .DATA_W    (DATA_W)
  ) u_rom (
    .sel (rom_sel),
    .idx (idx_d),
    .chr (rom_chr),
    .len (rom_len)
  );

  assign accept = en && valid_q && stream.char_ready;
  assign last   = (LEN_W'(idx_q) == rom_len - LEN_W'(1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    loop_d    = loop_q;
    div_d     = div_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    load_char = 1'b0;
    if (abort) begin
      state_d = StIdle;
      valid_d = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (en) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sel_d  = msg_sel;
            loop_d = loop_mode;
            div_d  = rate_div;
            idx_d  = '0;
            cnt_d  = '0;
            if (rom_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d   = StSend;
              valid_d   = 1'b1;
              load_char = 1'b1;
            end
          end
        end
        StSend: begin
          if (accept) begin
            done_d = last;
            idx_d  = last ? '0 : idx_q + 1'b1;
            if (last && !loop_q) begin
              state_d = StIdle;
              valid_d = 1'b0;
            end else if (div_q == '0) begin
              load_char = 1'b1;
            end else begin
              state_d = StGap;
              valid_d = 1'b0;
              cnt_d   = div_q;
            end
          end
        end
        StGap: begin
          if (cnt_q <= DIV_W'(1)) begin
            state_d   = StSend;
            valid_d   = 1'b1;
            load_char = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign char_d = load_char ? rom_chr : char_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      loop_q  <= 1'b0;
      div_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      loop_q  <= loop_d;
      div_q   <= div_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      char_q  <= char_d;
    end
  end

  assign stream.char_out   = char_q;
  assign stream.char_valid = valid_q;
  assign busy              = (state_q != StIdle);
  assign done              = done_q & en;

endmodule

// File: tb/tb_message_streamer.sv
// Directed bench for message_streamer; three messages configured so select 3 is out of range.
module tb_message_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        start;
  logic        abort;
  logic [1:0]  msg_sel;
  logic        loop_mode;
  logic [15:0] rate_div;
  logic        busy;
  logic        done;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    dones;
  string m0 = "Tajumulco Tacana Acatenango Fuego Sa";

  message_streamer_if #(.DATA_W(8)) stream ();

  message_streamer #(
    .MSG_COUNT (3),
    .MSG_DEPTH (64),
    .DATA_W    (8),
    .DIV_W     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .abort     (abort),
    .msg_sel   (msg_sel),
    .loop_mode (loop_mode),
    .rate_div  (rate_div),
    .stream    (stream),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic [1:0] sel, input logic lp, input logic [15:0] div);
    msg_sel   = sel;
    loop_mode = lp;
    rate_div  = div;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; abort = 1'b0;
    msg_sel = '0; loop_mode = 1'b0; rate_div = '0;
    stream.char_ready = 1'b1;
    #12;
    check_eq("rst_valid", stream.char_valid, 0);
    check_eq("rst_char", stream.char_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // One-shot, full throughput
    start_msg(2'd0, 1'b0, 16'd0);
    check_eq("a_first", stream.char_out, 8'h54);
    for (int i = 0; i < 36; i++) begin
      check_eq("a_valid", stream.char_valid, 1);
      check_eq("a_char", stream.char_out, m0[i]);
      check_eq("a_no_done", done, 0);
      if (i == 35) check_eq("a_last", stream.char_out, 8'h61);
      tick();
    end
    check_eq("a_done", done, 1);
    check_eq("a_busy_end", busy, 0);
    check_eq("a_valid_end", stream.char_valid, 0);
    tick();
    check_eq("a_done_once", done, 0);

    // Loop mode with 3-cycle gap, then abort+start together
    start_msg(2'd0, 1'b1, 16'd3);
    dones = 0;
    for (int i = 0; i < 36; i++) begin
      check_eq("b_valid", stream.char_valid, 1);
      check_eq("b_char", stream.char_out, m0[i]);
      tick();
      for (int g = 0; g < 3; g++) begin
        check_eq("b_gap", stream.char_valid, 0);
        if (done) dones++;
        tick();
      end
    end
    check_eq("b_done_count", dones, 1);
    check_eq("b_wrap_valid", stream.char_valid, 1);
    check_eq("b_wrap_char", stream.char_out, 8'h54);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check_eq("b_abort_valid", stream.char_valid, 0);
    check_eq("b_abort_busy", busy, 0);
    check_eq("b_abort_done", done, 0);
    tick();
    check_eq("b_abort_idle", busy, 0);

    // Backpressure on char 2 with an ignored start
    start_msg(2'd0, 1'b0, 16'd0);
    tick();
    tick();
    check_eq("c_char2", stream.char_out, 8'h6A);
    stream.char_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        start   = 1'b1;
        msg_sel = 2'd1;
      end
      tick();
      start = 1'b0;
      check_eq("c_hold_valid", stream.char_valid, 1);
      check_eq("c_hold_char", stream.char_out, 8'h6A);
    end
    stream.char_ready = 1'b1;
    tick();
    check_eq("c_resume", stream.char_out, 8'h75);
    check_eq("c_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // en low for 4 cycles inside a 5-cycle gap
    start_msg(2'd1, 1'b0, 16'd5);
    check_eq("d_first_valid", stream.char_valid, 1);
    check_eq("d_first_char", stream.char_out, 8'h48);
    for (int c = 1; c <= 9; c++) begin
      tick();
      check_eq("d_gap_low", stream.char_valid, 0);
      check_eq("d_gap_busy", busy, 1);
      if (c == 2) en = 1'b0;
      if (c == 6) en = 1'b1;
    end
    tick();
    check_eq("d_second_valid", stream.char_valid, 1);
    check_eq("d_second_char", stream.char_out, 8'h69);
    tick();
    check_eq("d_done", done, 1);
    check_eq("d_idle", busy, 0);
    check_eq("d_valid_end", stream.char_valid, 0);

    // Out-of-range select
    start_msg(2'd3, 1'b0, 16'd0);
    check_eq("e_done", done, 1);
    check_eq("e_valid", stream.char_valid, 0);
    check_eq("e_busy", busy, 0);
    tick();
    check_eq("e_done_once", done, 0);
    check_eq("e_valid_after", stream.char_valid, 0);

    // Asynchronous reset while sending
    start_msg(2'd0, 1'b0, 16'd0);
    check_eq("f_valid_before", stream.char_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("f_rst_valid", stream.char_valid, 0);
    check_eq("f_rst_char", stream.char_out, 0);
    check_eq("f_rst_busy", busy, 0);
    #3 rst_n = 1'b1;
    tick();
    tick();
    check_eq("f_stay_idle", busy, 0);
    check_eq("f_stay_invalid", stream.char_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
